// File: rtl/stack_pkg.sv
// Shared encodings for the hardware data stack: command opcodes and FSM states.
package stack_pkg;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_PUSH    = 2'b01;
  localparam logic [1:0] OP_POP     = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_REFILL  = 1'b1;

endpackage

// File: rtl/stack_ram.sv
// Single-port block RAM with synchronous read (one-cycle latency) holding the
// stack cells below TOS. No reset so it maps onto iCE40 BRAM.
module stack_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  input  logic             we,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned CELLS = 1 << AW;

  logic [WIDTH-1:0] mem [0:CELLS-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/data_stack.sv
// Data stack: TOS held in a register, deeper cells in a synchronous-read RAM.
// Multi-cell POP takes a REFILL cycle to load the new TOS from RAM.
module data_stack
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] tos,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             err_overflow,
  output logic             err_underflow,
  input  logic             err_clear
);

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_TWO  = (AW+1)'(2);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] tos_q,   tos_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q,   ovf_d;
  logic             unf_q,   unf_d;

  logic [AW-1:0]    ram_addr;
  logic             ram_we;
  logic [WIDTH-1:0] ram_dout;

  logic             is_empty, is_full;

  assign is_empty      = (count_q == '0);
  assign is_full       = (count_q == CNT_FULL);

  assign cmd_ready     = (state_q == ST_IDLE);
  assign tos           = tos_q;
  assign count         = count_q;
  assign empty         = is_empty;
  assign full          = is_full;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

  stack_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .din  (tos_q),
    .we   (ram_we),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tos_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tos_q   <= tos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Next-state: at most one RAM access per cycle (write on PUSH, read on POP).
  always_comb begin
    state_d  = state_q;
    tos_d    = tos_q;
    count_d  = count_q;
    ovf_d    = ovf_q & ~err_clear;
    unf_d    = unf_q & ~err_clear;
    ram_addr = '0;
    ram_we   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PUSH: begin
              if (is_full) begin
                ovf_d = 1'b1;
              end else begin
                if (!is_empty) begin
                  ram_we   = 1'b1;
                  ram_addr = AW'(count_q - CNT_ONE);
                end
                tos_d   = cmd_data;
                count_d = count_q + CNT_ONE;
              end
            end
            OP_POP: begin
              if (is_empty) begin
                unf_d = 1'b1;
              end else if (count_q == CNT_ONE) begin
                tos_d   = '0;
                count_d = '0;
              end else begin
                ram_addr = AW'(count_q - CNT_TWO);
                count_d  = count_q - CNT_ONE;
                state_d  = ST_REFILL;
              end
            end
            OP_REPLACE: begin
              if (is_empty) unf_d = 1'b1;
              else          tos_d = cmd_data;
            end
            default: ;
          endcase
        end
      end
      ST_REFILL: begin
        tos_d   = ram_dout;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_stack.sv
// Scoreboard bench for data_stack: three configurations (4x8, 8x8, 256x32)
// driven by directed and random commands, checked against a queue model.
module tb_data_stack;

  localparam logic [1:0] C_NOP = 2'b00;
  localparam logic [1:0] C_PSH = 2'b01;
  localparam logic [1:0] C_POP = 2'b10;
  localparam logic [1:0] C_REP = 2'b11;

  typedef struct {
    logic [31:0] tos;
    int          cnt;
    bit          ovf;
    bit          unf;
  } exp_t;

  logic clk = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   done [3];

  always #5 clk = ~clk;

  task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL inst%0d %s: got 0x%0h expected 0x%0h at %0t", g, nm, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int unsigned W   = (g == 2) ? 32 : 8;
    localparam int unsigned DEP = (g == 0) ? 4 : ((g == 1) ? 8 : 256);
    localparam int unsigned AWL = $clog2(DEP);

    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [W-1:0]   cmd_data;
    logic [W-1:0]   tos;
    logic [AWL:0]   count;
    logic           empty;
    logic           full;
    logic           err_overflow;
    logic           err_underflow;
    logic           err_clear;

    exp_t        sb[$];
    logic [31:0] m_stk[$];
    bit          m_ovf;
    bit          m_unf;

    data_stack #(
      .WIDTH (W),
      .DEPTH (DEP)
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_data      (cmd_data),
      .tos           (tos),
      .count         (count),
      .empty         (empty),
      .full          (full),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow),
      .err_clear     (err_clear)
    );

    // Issue one command, update the model, queue the expected post-state.
    task automatic issue(input logic [1:0] op, input logic [31:0] val, input bit clr, input bit no_tail);
      logic [W-1:0] d;
      int           n;
      bit           stall;
      exp_t         e;
      d = W'(val);
      @(negedge clk);
      n = 0;
      while (!cmd_ready && n < 8) begin
        @(negedge clk);
        n++;
      end
      if (!cmd_ready) chk(g, "ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      err_clear = clr;
      stall = 1'b0;
      m_ovf = m_ovf && !clr;
      m_unf = m_unf && !clr;
      case (op)
        C_PSH: if (m_stk.size() == DEP) m_ovf = 1'b1; else m_stk.push_back(32'(d));
        C_POP: if (m_stk.size() == 0) m_unf = 1'b1;
               else begin
                 stall = (m_stk.size() >= 2);
                 void'(m_stk.pop_back());
               end
        C_REP: if (m_stk.size() == 0) m_unf = 1'b1; else m_stk[m_stk.size()-1] = 32'(d);
        default: ;
      endcase
      @(posedge clk);
      e.tos = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 32'd0;
      e.cnt = m_stk.size();
      e.ovf = m_ovf;
      e.unf = m_unf;
      sb.push_back(e);
      #1;
      cmd_valid = 1'b0;
      err_clear = 1'b0;
      chk(g, "ready_after_accept", 32'(cmd_ready), stall ? 32'd0 : 32'd1);
      if (stall && !no_tail) begin
        @(posedge clk);
        #1;
        chk(g, "ready_after_refill", 32'(cmd_ready), 32'd1);
      end
    endtask

    // Monitor: each accepted command yields one result once cmd_ready is high.
    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        if (!rst && cmd_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk(g, "tos",   32'(tos),           e.tos);
          chk(g, "count", 32'(count),         32'(e.cnt));
          chk(g, "empty", 32'(empty),         32'(e.cnt == 0));
          chk(g, "full",  32'(full),          32'(e.cnt == DEP));
          chk(g, "ovf",   32'(err_overflow),  32'(e.ovf));
          chk(g, "unf",   32'(err_underflow), 32'(e.unf));
        end
      end
    end

    initial begin
      int r;
      int n;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = C_NOP;
      cmd_data = '0;
      err_clear = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      @(negedge clk);
      chk(g, "rst_tos",   32'(tos),       32'd0);
      chk(g, "rst_count", 32'(count),     32'd0);
      chk(g, "rst_ready", 32'(cmd_ready), 32'd1);
      chk(g, "rst_empty", 32'(empty),     32'd1);
      chk(g, "rst_flags", 32'({err_overflow, err_underflow}), 32'd0);
      rst = 1'b0;

      issue(C_PSH, 32'h11, 0, 0);
      issue(C_PSH, 32'h22, 0, 0);
      issue(C_PSH, 32'h33, 0, 0);
      repeat (3) issue(C_POP, 0, 0, 0);

      for (int i = 1; i <= DEP; i++) issue(C_PSH, 32'(i), 0, 0);
      issue(C_PSH, 32'(DEP + 1), 0, 0);
      for (int i = 0; i < DEP; i++) issue(C_POP, 0, 0, 0);
      issue(C_NOP, 0, 1, 0);

      issue(C_POP, 0, 0, 0);
      issue(C_REP, 32'hAB, 0, 0);
      issue(C_POP, 0, 1, 0);
      issue(C_NOP, 0, 1, 0);

      issue(C_PSH, 32'h7, 0, 0);
      issue(C_PSH, 32'h9, 0, 0);
      issue(C_REP, 32'h5A, 0, 0);
      issue(C_POP, 0, 0, 0);
      issue(C_POP, 0, 0, 0);

      // Reset during the REFILL cycle discards the pending pop result.
      issue(C_PSH, 32'h1, 0, 0);
      issue(C_PSH, 32'h2, 0, 0);
      issue(C_POP, 0, 0, 1);
      rst = 1'b1;
      sb.delete();
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      @(negedge clk);
      chk(g, "midrst_tos",   32'(tos),       32'd0);
      chk(g, "midrst_count", 32'(count),     32'd0);
      chk(g, "midrst_ready", 32'(cmd_ready), 32'd1);
      rst = 1'b0;
      issue(C_PSH, 32'h3, 0, 0);

      for (int i = 0; i < 400; i++) begin
        r = $urandom_range(0, 9);
        issue((r < 5) ? C_PSH : (r < 8) ? C_POP : (r == 8) ? C_REP : C_NOP,
              $urandom, ($urandom_range(0, 7) == 0), 0);
      end

      n = 0;
      while (sb.size() > 0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() > 0) chk(g, "drain", 32'(sb.size()), 32'd0);
      done[g] = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(done[0] && done[1] && done[2]) && cyc < 50000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(done[0] && done[1] && done[2])) begin
      checks++;
      failures++;
      $display("FAIL timeout: stimulus did not complete within %0d cycles", cyc);
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
